// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with valid/grant data-memory port,
// store lane formatting, load extension and the MEM/WB pipeline register.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rstN,
  input  logic        regWrtm,
  input  logic        memWrtm,
  input  logic [1:0]  rsltSrcm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  input  logic [31:0] pc4m,
  input  logic [4:0]  rdm,
  output logic        stallM,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [3:0]  dmBe,
  output logic [31:0] dmWdata,
  input  logic        dmGnt,
  input  logic        dmRvalid,
  input  logic [31:0] dmRdata,
  output logic        regWrtw,
  output logic [1:0]  rsltSrcw,
  output logic [31:0] aluRsltw,
  output logic [31:0] pc4w,
  output logic [4:0]  rdw,
  output logic [31:0] readDw,
  output logic        misalignW
);
  typedef enum logic {IDLE, WAIT} stateT;
  stateT state, stateNxt;
  logic isStore, isLoad, isHalf, isWord, misalign, memOp, loadDone;
  logic [31:0] shifted, loadExt;
  always_comb begin
    isStore  = memWrtm;
    isLoad   = !memWrtm && rsltSrcm == 2'b01;
    isHalf   = funct3m[1:0] == 2'b01;
    isWord   = funct3m[1];
    misalign = (isStore || isLoad) && ((isHalf && aluRsltm[0]) || (isWord && aluRsltm[1:0] != 2'b00));
    memOp    = (isStore || isLoad) && !misalign;
    // reset must silence the port and the stall even while EX/MEM still shows a memory op
    dmReq    = rstN && state == IDLE && memOp;
    loadDone = rstN && state == WAIT && dmRvalid;
    stallM   = (dmReq && !(isStore && dmGnt)) || (rstN && state == WAIT && !dmRvalid);
    stateNxt = state == IDLE ? (dmReq && isLoad && dmGnt ? WAIT : IDLE) : (dmRvalid ? IDLE : WAIT);
    dmWe     = isStore;
    dmAddr   = {aluRsltm[31:2], 2'b00};
    dmBe     = isWord ? 4'b1111 : isHalf ? (aluRsltm[1] ? 4'b1100 : 4'b0011) : 4'b0001 << aluRsltm[1:0];
    dmWdata  = isWord ? wrtDm : isHalf ? {2{wrtDm[15:0]}} : {4{wrtDm[7:0]}};
    shifted  = dmRdata >> {aluRsltm[1:0], 3'b000};
    loadExt  = isWord ? shifted
             : isHalf ? {{16{!funct3m[2] && shifted[15]}}, shifted[15:0]}
             : {{24{!funct3m[2] && shifted[7]}}, shifted[7:0]};
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      regWrtw   <= 1'b0;
      misalignW <= 1'b0;
      rsltSrcw  <= '0;
      aluRsltw  <= '0;
      pc4w      <= '0;
      rdw       <= '0;
      readDw    <= '0;
    end else begin
      state     <= stateNxt;
      regWrtw   <= !stallM && regWrtm && !misalign;
      misalignW <= !stallM && misalign;
      if (!stallM) begin
        rsltSrcw <= rsltSrcm;
        aluRsltw <= aluRsltm;
        pc4w     <= pc4m;
        rdw      <= rdm;
      end
      if (loadDone) readDw <= loadExt;
    end
  end
endmodule
